// File: rtl/morse_char_decoder.sv
// morse_char_decoder
// Collects dot/dash symbols from the push-button Morse symbol detector into a
// pattern of up to five symbols and, on a character space, translates the
// pattern into an uppercase ASCII character using the ITU Morse table.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   sym_in     symbol: 00 idle, 01 dot, 10 dash, 11 character space
//   char_out   ASCII code of the last decoded character (held between strobes)
//   char_valid one-cycle strobe, char_out has just been updated
//   err        one-cycle strobe with char_valid when the pattern was unmapped
//              or overflowed (char_out = '?')
//   sym_count  number of symbols buffered for the current character (0-5)
//   busy       high while a character is being collected
module morse_char_decoder (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] sym_in,
   output logic [7:0] char_out,
   output logic       char_valid,
   output logic       err,
   output logic [2:0] sym_count,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COLLECT  = 2'd1,
      OVERFLOW = 2'd2
   } state_t;

   state_t     state, state_nx;
   logic [4:0] pat, pat_nx;
   logic [2:0] len, len_nx;
   logic [7:0] char_nx;
   logic       valid_nx;
   logic       err_nx;

   // Returns {err, ascii}. The key is {len, pat}; pat holds the first symbol
   // at bit len-1 and the latest at bit 0 (dot = 0, dash = 1). Bits above
   // len-1 are always zero because pat is cleared between characters.
   function automatic logic [8:0] morse_lookup(input logic [2:0] l, input logic [4:0] p);
      logic [8:0] r;
      case ({l, p})
         {3'd1, 5'b00000}: r = {1'b0, 8'h45}; // E .
         {3'd1, 5'b00001}: r = {1'b0, 8'h54}; // T -
         {3'd2, 5'b00000}: r = {1'b0, 8'h49}; // I ..
         {3'd2, 5'b00001}: r = {1'b0, 8'h41}; // A .-
         {3'd2, 5'b00010}: r = {1'b0, 8'h4E}; // N -.
         {3'd2, 5'b00011}: r = {1'b0, 8'h4D}; // M --
         {3'd3, 5'b00000}: r = {1'b0, 8'h53}; // S
         {3'd3, 5'b00001}: r = {1'b0, 8'h55}; // U
         {3'd3, 5'b00010}: r = {1'b0, 8'h52}; // R
         {3'd3, 5'b00011}: r = {1'b0, 8'h57}; // W
         {3'd3, 5'b00100}: r = {1'b0, 8'h44}; // D
         {3'd3, 5'b00101}: r = {1'b0, 8'h4B}; // K
         {3'd3, 5'b00110}: r = {1'b0, 8'h47}; // G
         {3'd3, 5'b00111}: r = {1'b0, 8'h4F}; // O
         {3'd4, 5'b00000}: r = {1'b0, 8'h48}; // H
         {3'd4, 5'b00001}: r = {1'b0, 8'h56}; // V
         {3'd4, 5'b00010}: r = {1'b0, 8'h46}; // F
         {3'd4, 5'b00100}: r = {1'b0, 8'h4C}; // L
         {3'd4, 5'b00110}: r = {1'b0, 8'h50}; // P
         {3'd4, 5'b00111}: r = {1'b0, 8'h4A}; // J
         {3'd4, 5'b01000}: r = {1'b0, 8'h42}; // B
         {3'd4, 5'b01001}: r = {1'b0, 8'h58}; // X
         {3'd4, 5'b01010}: r = {1'b0, 8'h43}; // C
         {3'd4, 5'b01011}: r = {1'b0, 8'h59}; // Y
         {3'd4, 5'b01100}: r = {1'b0, 8'h5A}; // Z
         {3'd4, 5'b01101}: r = {1'b0, 8'h51}; // Q
         {3'd5, 5'b11111}: r = {1'b0, 8'h30}; // 0
         {3'd5, 5'b01111}: r = {1'b0, 8'h31}; // 1
         {3'd5, 5'b00111}: r = {1'b0, 8'h32}; // 2
         {3'd5, 5'b00011}: r = {1'b0, 8'h33}; // 3
         {3'd5, 5'b00001}: r = {1'b0, 8'h34}; // 4
         {3'd5, 5'b00000}: r = {1'b0, 8'h35}; // 5
         {3'd5, 5'b10000}: r = {1'b0, 8'h36}; // 6
         {3'd5, 5'b11000}: r = {1'b0, 8'h37}; // 7
         {3'd5, 5'b11100}: r = {1'b0, 8'h38}; // 8
         {3'd5, 5'b11110}: r = {1'b0, 8'h39}; // 9
         default:          r = {1'b1, 8'h3F}; // '?'
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         pat        <= 5'd0;
         len        <= 3'd0;
         char_out   <= 8'h00;
         char_valid <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_nx;
         pat        <= pat_nx;
         len        <= len_nx;
         char_out   <= char_nx;
         char_valid <= valid_nx;
         err        <= err_nx;
      end
   end

   always_comb begin
      state_nx = state;
      pat_nx   = pat;
      len_nx   = len;
      char_nx  = char_out;
      valid_nx = 1'b0;
      err_nx   = 1'b0;
      case (state)
         IDLE: begin
            // A space with an empty buffer (including repeated spaces from
            // the detector) is ignored here.
            if (sym_in == 2'b01 || sym_in == 2'b10) begin
               pat_nx   = {4'b0000, sym_in[1]};
               len_nx   = 3'd1;
               state_nx = COLLECT;
            end
         end
         COLLECT: begin
            if (sym_in == 2'b01 || sym_in == 2'b10) begin
               if (len < 3'd5) begin
                  pat_nx = {pat[3:0], sym_in[1]};
                  len_nx = len + 3'd1;
               end else begin
                  state_nx = OVERFLOW;
               end
            end else if (sym_in == 2'b11) begin
               {err_nx, char_nx} = morse_lookup(len, pat);
               valid_nx = 1'b1;
               pat_nx   = 5'd0;
               len_nx   = 3'd0;
               state_nx = IDLE;
            end
         end
         OVERFLOW: begin
            if (sym_in == 2'b11) begin
               char_nx  = 8'h3F;
               valid_nx = 1'b1;
               err_nx   = 1'b1;
               pat_nx   = 5'd0;
               len_nx   = 3'd0;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign sym_count = len;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_morse_char_decoder.sv
// Directed testbench for morse_char_decoder. Inputs change 1 ns after the
// rising edge; outputs are sampled at that same point, i.e. after the edge
// that consumed the previous symbol.
module tb_morse_char_decoder;

   logic       clk;
   logic       rst;
   logic [1:0] sym_in;
   logic [7:0] char_out;
   logic       char_valid;
   logic       err;
   logic [2:0] sym_count;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int strobes;
   int busy_seen;

   morse_char_decoder dut (
      .clk        (clk),
      .rst        (rst),
      .sym_in     (sym_in),
      .char_out   (char_out),
      .char_valid (char_valid),
      .err        (err),
      .sym_count  (sym_count),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one symbol, let the next rising edge consume it, then settle.
   task automatic step(input logic [1:0] s);
      sym_in = s;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_strobe(input string tag, input logic [7:0] c, input logic e);
      chk({tag, "_char"}, {24'd0, char_out}, {24'd0, c});
      chk({tag, "_valid"}, {31'd0, char_valid}, 32'd1);
      chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
      chk({tag, "_count"}, {29'd0, sym_count}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      rst    = 1'b1;
      sym_in = 2'b00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      chk("rst_char", {24'd0, char_out}, 32'h00);
      chk("rst_valid", {31'd0, char_valid}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_count", {29'd0, sym_count}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);

      // A: .- then space
      step(2'b01);
      chk("A_count1", {29'd0, sym_count}, 32'd1);
      chk("A_busy1", {31'd0, busy}, 32'd1);
      step(2'b10);
      chk("A_count2", {29'd0, sym_count}, 32'd2);
      step(2'b11);
      chk_strobe("A", 8'h41, 1'b0);

      // Dash directly after the strobe starts a new character; strobe drops
      step(2'b10);
      chk("zero_valid_drop", {31'd0, char_valid}, 32'd0);
      chk("zero_char_hold", {24'd0, char_out}, 32'h41);
      chk("zero_count1", {29'd0, sym_count}, 32'd1);
      repeat (4) step(2'b10);
      chk("zero_count5", {29'd0, sym_count}, 32'd5);
      step(2'b11);
      chk_strobe("zero", 8'h30, 1'b0);

      // 5: five dots
      repeat (5) step(2'b01);
      chk("five_count5", {29'd0, sym_count}, 32'd5);
      step(2'b11);
      chk_strobe("five", 8'h35, 1'b0);

      // E followed by a held space: exactly one strobe
      step(2'b01);
      step(2'b11);
      chk_strobe("E", 8'h45, 1'b0);
      strobes   = 0;
      busy_seen = 0;
      for (int i = 0; i < 20; i++) begin
         step(2'b11);
         if (char_valid) strobes++;
         if (busy) busy_seen++;
      end
      chk("E_extra_strobes", strobes, 0);
      chk("E_busy_during_space", busy_seen, 0);

      // Overflow: six dots
      repeat (6) step(2'b01);
      chk("ovf_count_sat", {29'd0, sym_count}, 32'd5);
      chk("ovf_busy", {31'd0, busy}, 32'd1);
      chk("ovf_no_strobe", {31'd0, char_valid}, 32'd0);
      step(2'b11);
      chk_strobe("ovf", 8'h3F, 1'b1);
      step(2'b01);
      chk("post_ovf_err_drop", {31'd0, err}, 32'd0);
      step(2'b11);
      chk_strobe("post_ovf_E", 8'h45, 1'b0);

      // Unmapped .-.-
      step(2'b01);
      step(2'b10);
      step(2'b01);
      step(2'b10);
      step(2'b11);
      chk_strobe("unmapped", 8'h3F, 1'b1);

      // Async reset mid-character
      step(2'b10);
      step(2'b01);
      chk("pre_rst_count", {29'd0, sym_count}, 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("arst_char", {24'd0, char_out}, 32'h00);
      chk("arst_valid", {31'd0, char_valid}, 32'd0);
      chk("arst_err", {31'd0, err}, 32'd0);
      chk("arst_count", {29'd0, sym_count}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      sym_in = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      step(2'b11);
      chk("rel_space_valid", {31'd0, char_valid}, 32'd0);
      chk("rel_space_busy", {31'd0, busy}, 32'd0);
      chk("rel_space_char", {24'd0, char_out}, 32'h00);
      step(2'b10);
      chk("T_count1", {29'd0, sym_count}, 32'd1);
      step(2'b11);
      chk_strobe("T", 8'h54, 1'b0);
      step(2'b00);
      chk("T_valid_drop", {31'd0, char_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/morse_char_decoder.md
# morse_char_decoder

Consumes the 2-bit symbol stream produced by the push-button Morse symbol detector: dot = 01, dash = 10, character space = 11, idle = 00. It accumulates dots and dashes into a pattern of up to 5 symbols. On character space it looks the pattern up in the ITU Morse table and emits one uppercase ASCII character with a one-cycle valid strobe. It sits between the symbol detector and the display/UART output stage.

## Interface
- No parameters; the table size and maximum of 5 symbols are fixed.
- clk  input  1  system clock (50 MHz).
- rst  input  1  asynchronous, active-high reset.
- sym_in  input  2  symbol from the detector: 00 idle, 01 dot, 10 dash, 11 character space.
- char_out  output  8  ASCII code of the last decoded character; holds its value between strobes.
- char_valid  output  1  one-cycle strobe: char_out has just been updated.
- err  output  1  one-cycle strobe, coincident with char_valid, when the pattern was unmapped or overflowed.
- sym_count  output  3  number of symbols buffered for the current character, 0–5.
- busy  output  1  high while a character is being collected (state not IDLE).

## Operation
- Internal storage: 5-bit pattern register `pat` and length counter `len` (3 bits).
  - Symbols shift into `pat` at the LSB: dot = 0, dash = 1.
  - Example: A (.-) gives len = 2, pat[1:0] = 01.
- The lookup key is {len, pat}. The table covers A–Z → 0x41–0x5A and 0–9 → 0x30–0x39, all standard ITU codes.
  - Any other key decodes to '?' (0x3F) with err = 1.
- FSM states: IDLE, COLLECT, OVERFLOW.
  - **IDLE**
    - 01/10: pat = bit, len = 1, go to COLLECT.
    - 00/11: stay. A character space with an empty buffer is ignored, so no strobe is produced.
  - **COLLECT**
    - 00: hold.
    - 01/10 with len < 5: shift the bit in and increment len.
    - 01/10 with len = 5: go to OVERFLOW; pat and len are frozen.
    - 11: register the lookup result, pulse char_valid, clear len and pat, go to IDLE.
  - **OVERFLOW**
    - 00/01/10: stay, ignoring the symbols.
    - 11: char_out = 0x3F, pulse char_valid and err, clear len and pat, go to IDLE.
- The detector repeats 11 for as long as the input stays released. Only the first 11 after a dot or dash produces a character; later 11s land in IDLE and are ignored.
- Back-to-back symbols on consecutive cycles are accepted, with no idle gap required.
- sym_count = len. It holds at 5 while in OVERFLOW.
- busy = (state != IDLE).

## Timing
- Reset (async assert, released synchronously to clk):
  - state = IDLE, len = 0, pat = 0.
  - char_out = 0x00, char_valid = 0, err = 0, sym_count = 0, busy = 0.
- All outputs are registered. There is no combinational path from sym_in to any output.
- Latency: an 11 sampled at edge N updates char_out, char_valid and err at edge N, so they are visible in cycle N+1.
- char_valid and err are exactly one cycle wide and deassert on the next edge.
- Reset asserted mid-character discards the partial pattern and generates no strobe. The first dot after release starts a fresh character.
- A dot/dash in the cycle immediately after a strobe starts a new character normally: len = 1.
- Throughput: at most one character per two cycles (one symbol followed by one space).

## Test plan
- Reset, then sym_in = 01, 10, 11 on consecutive cycles → one cycle after the 11: char_out = 0x41, char_valid = 1 for one cycle, err = 0, sym_count returns to 0.
- Five cycles of 10 then 11 → char_out = 0x30 ('0'). Then 01 ×5, 11 → char_out = 0x35 ('5'). sym_count reads 5 just before each 11.
- 01, 11 followed by 11 held for 20 cycles → exactly one strobe with char_out = 0x45 ('E'), and busy = 0 throughout the repeated 11s.
- Six 01 symbols, then 11 → sym_count saturates at 5, busy = 1; on the 11: char_out = 0x3F, char_valid = 1, err = 1. The next 01, 11 gives 0x45 with err = 0.
- Unmapped pattern 01, 10, 01, 10, 11 (.-.-) → char_out = 0x3F, err = 1.
- Send 10, 01, then pulse rst high asynchronously mid-cycle → all outputs are 0 immediately. After release, 11 alone → no strobe; then 10, 11 → char_out = 0x54 ('T').
